file_server: RTL

- Peer-side responder for the byte-serial file transfer protocol spoken by the FPGA memory/IO stage over the rs232 link.
- Parses the command frame: head byte 'R'/'W', then a 2-byte file index, MSB first.
- For 'R' (initiator reads), it streams the file's bytes out of a backing store.
- For 'W' (initiator writes), it absorbs the file's bytes into that store.
- Sits between an rs232 byte interface and a synchronous byte RAM; used as the host-side peer and as the loopback partner for board/sim bring-up.

---
 rtl/file_server.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/file_server.sv
// Byte-serial file transfer responder: parses 'R'/'W' + 16-bit index frames and
// streams file bytes between an rs232 byte link and a synchronous byte RAM.
module file_server #(
    parameter int IntSize = 8,
    parameter int TIMEOUT = 1000000,
    parameter int TO_W    = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IntSize-1:0] rx_data,
    input  logic               rx_rdy,
    output logic [IntSize-1:0] tx_data,
    output logic               tx_en,
    input  logic               tx_busy,
    output logic [15:0]        file_idx,
    input  logic [15:0]        file_len,
    output logic [15:0]        mem_addr,
    output logic               mem_re,
    input  logic [IntSize-1:0] mem_rdata,
    output logic               mem_we,
    output logic [IntSize-1:0] mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err
);

    // Handshake: rx_rdy is a one-cycle strobe qualifying rx_data; tx_en is a
    // one-cycle request issued only while tx_busy is low, and tx_data is held
    // until the next request; mem_rdata is valid the cycle after mem_re.
    typedef enum logic [3:0] {
        IDLE, IDX_HI, IDX_LO, LOOKUP, RD_FETCH, RD_SEND, RD_WAIT, WR_RECV, FIN
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t              state, state_nxt;
    logic                dir_rd, dir_nxt;
    logic [15:0]         len, len_nxt;
    logic [15:0]         offset, off_nxt, off_inc;
    logic [TO_W-1:0]     to_cnt, to_nxt;
    logic                timed_out;
    logic                tx_en_q;
    logic [15:0]         idx_nxt, addr_nxt;
    logic [IntSize-1:0]  tx_data_nxt, wdata_nxt;
    logic                tx_en_nxt, mem_re_nxt, mem_we_nxt, done_nxt, err_nxt;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dir_rd    <= 1'b0;
            len       <= '0;
            offset    <= '0;
            to_cnt    <= '0;
            tx_en_q   <= 1'b0;
            file_idx  <= '0;
            tx_data   <= '0;
            tx_en     <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_addr  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            dir_rd    <= dir_nxt;
            len       <= len_nxt;
            offset    <= off_nxt;
            to_cnt    <= to_nxt;
            tx_en_q   <= tx_en;
            file_idx  <= idx_nxt;
            tx_data   <= tx_data_nxt;
            tx_en     <= tx_en_nxt;
            mem_re    <= mem_re_nxt;
            mem_we    <= mem_we_nxt;
            mem_wdata <= wdata_nxt;
            mem_addr  <= addr_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        dir_nxt     = dir_rd;
        len_nxt     = len;
        off_nxt     = offset;
        to_nxt      = '0;
        idx_nxt     = file_idx;
        tx_data_nxt = tx_data;
        tx_en_nxt   = 1'b0;
        mem_re_nxt  = 1'b0;
        mem_we_nxt  = 1'b0;
        wdata_nxt   = mem_wdata;
        addr_nxt    = mem_addr;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        off_inc     = offset + 16'd1;
        timed_out   = !rx_rdy && (to_cnt == TO_LAST);

        // Inter-byte watchdog only runs while the initiator owns the pacing.
        if (state inside {IDX_HI, IDX_LO, WR_RECV})
            to_nxt = rx_rdy ? '0 : to_cnt + TO_W'(1);

        case (state)
            IDLE: begin
                if (rx_rdy) begin
                    if (rx_data == 8'h52) begin
                        dir_nxt   = 1'b1;
                        state_nxt = IDX_HI;
                    end else if (rx_data == 8'h57) begin
                        dir_nxt   = 1'b0;
                        state_nxt = IDX_HI;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            IDX_HI: begin
                if (rx_rdy) begin
                    idx_nxt[15:8] = rx_data;
                    state_nxt     = IDX_LO;
                end else if (timed_out) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            IDX_LO: begin
                if (rx_rdy) begin
                    idx_nxt[7:0] = rx_data;
                    state_nxt    = LOOKUP;
                end else if (timed_out) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            LOOKUP: begin
                len_nxt = file_len;
                off_nxt = '0;
                if (file_len == 16'd0) begin
                    done_nxt  = 1'b1;
                    state_nxt = FIN;
                end else if (dir_rd) begin
                    mem_re_nxt = 1'b1;
                    addr_nxt   = '0;
                    state_nxt  = RD_FETCH;
                end else begin
                    state_nxt = WR_RECV;
                end
            end
            RD_FETCH: state_nxt = RD_SEND;
            RD_SEND: begin
                if (!tx_busy) begin
                    tx_data_nxt = mem_rdata;
                    tx_en_nxt   = 1'b1;
                    state_nxt   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // The transmitter has not raised busy yet during and just after tx_en.
                if (!tx_en && !tx_en_q && !tx_busy) begin
                    off_nxt = off_inc;
                    if (off_inc == len) begin
                        done_nxt  = 1'b1;
                        state_nxt = FIN;
                    end else begin
                        mem_re_nxt = 1'b1;
                        addr_nxt   = off_inc;
                        state_nxt  = RD_FETCH;
                    end
                end
            end
            WR_RECV: begin
                if (rx_rdy) begin
                    addr_nxt   = offset;
                    wdata_nxt  = rx_data;
                    mem_we_nxt = 1'b1;
                    off_nxt    = off_inc;
                    if (off_inc == len) begin
                        done_nxt  = 1'b1;
                        state_nxt = FIN;
                    end
                end else if (timed_out) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule
